aes_round_ctrl: RTL and testbench

Round-sequencing controller for the AES core. It accepts one block per valid/ready handshake and steps the datapath through the initial AddRoundKey, the NUM_ROUNDS-1 full rounds and the final round, which skips MixColumns. It stalls on round-key availability from key expansion and presents completion through a valid/ready output handshake. It is the initiator that drives the round-count/last-round protocol that `aes_round_counter` serves. It sits between the block input interface and the cipher datapath/key schedule.

---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_round_ctrl.sv | 106 ++++++++++
 tb/tb_aes_round_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES controller definitions: FSM state encoding, standard round
// counts and round-index width sizing.
package aes_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      ROUND,
      FINAL,
      OUT
   } aes_state_e;

   localparam int unsigned AES128_ROUNDS = 10;
   localparam int unsigned AES192_ROUNDS = 12;
   localparam int unsigned AES256_ROUNDS = 14;

   // Smallest round-index width able to hold 0..num_rounds.
   function automatic int unsigned aes_min_cnt_size(input int unsigned num_rounds);
      int unsigned w;
      w = 0;
      while ((64'd1 << w) < (64'(num_rounds) + 64'd1)) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: accepts one block, steps INIT / full rounds / final
// round while stalling on key availability, then holds the result until taken.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = AES128_ROUNDS,
   parameter int unsigned CNT_SIZE   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_in_valid,
   output logic                o_in_ready,
   input  logic                i_key_valid,
   input  logic                i_abort,
   output logic [CNT_SIZE-1:0] o_round,
   output logic                o_ld_state,
   output logic                o_rnd_en,
   output logic                o_final,
   output logic                o_busy,
   output logic                o_out_valid,
   input  logic                i_out_ready
);

   localparam logic [CNT_SIZE-1:0] LAST_FULL = CNT_SIZE'(NUM_ROUNDS - 1);
   localparam logic [CNT_SIZE-1:0] LAST_RND  = CNT_SIZE'(NUM_ROUNDS);

   aes_state_e          r_state;
   aes_state_e          w_state_nxt;
   logic [CNT_SIZE-1:0] r_round;
   logic [CNT_SIZE-1:0] w_round_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_round <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_round <= w_round_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_round_nxt = r_round;
      o_in_ready  = 1'b0;
      o_ld_state  = 1'b0;
      o_rnd_en    = 1'b0;
      o_final     = 1'b0;
      o_out_valid = 1'b0;
      o_busy      = (r_state != IDLE);

      case (r_state)
         IDLE: begin
            // Gated by rst so nothing is offered while the block is held in reset.
            o_in_ready = ~i_abort & ~rst;
            if (i_in_valid) begin
               w_state_nxt = INIT;
               w_round_nxt = '0;
            end
         end
         INIT: begin
            o_ld_state = i_key_valid;
            if (i_key_valid) begin
               w_state_nxt = ROUND;
               w_round_nxt = CNT_SIZE'(1);
            end
         end
         ROUND: begin
            o_rnd_en = i_key_valid;
            if (i_key_valid) begin
               if (r_round == LAST_FULL) begin
                  w_state_nxt = FINAL;
                  w_round_nxt = LAST_RND;
               end else begin
                  w_round_nxt = r_round + 1'b1;
               end
            end
         end
         FINAL: begin
            o_final  = 1'b1;
            o_rnd_en = i_key_valid;
            if (i_key_valid) w_state_nxt = OUT;
         end
         OUT: begin
            o_out_valid = 1'b1;
            if (i_out_ready) begin
               w_state_nxt = IDLE;
               w_round_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_round_nxt = '0;
         end
      endcase

      // Abort overrides every transition, including an IDLE accept.
      if (i_abort) begin
         w_state_nxt = IDLE;
         w_round_nxt = '0;
      end
   end

   assign o_round = r_round;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed self-checking bench for aes_round_ctrl (10-round and 14-round builds).
module tb_aes_round_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, key_valid, abort, out_ready;
   logic       in_ready, ld_state, rnd_en, fin, busy, out_valid;
   logic [3:0] round;
   logic       in_valid2, key_valid2, abort2, out_ready2;
   logic       in_ready2, ld_state2, rnd_en2, fin2, busy2, out_valid2;
   logic [3:0] round2;
   logic [9:0] obs, obs2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_round_ctrl #(.NUM_ROUNDS(10), .CNT_SIZE(4)) dut (
      .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_key_valid(key_valid), .i_abort(abort), .o_round(round),
      .o_ld_state(ld_state), .o_rnd_en(rnd_en), .o_final(fin), .o_busy(busy),
      .o_out_valid(out_valid), .i_out_ready(out_ready)
   );

   aes_round_ctrl #(.NUM_ROUNDS(14), .CNT_SIZE(4)) dut14 (
      .clk(clk), .rst(rst), .i_in_valid(in_valid2), .o_in_ready(in_ready2),
      .i_key_valid(key_valid2), .i_abort(abort2), .o_round(round2),
      .o_ld_state(ld_state2), .o_rnd_en(rnd_en2), .o_final(fin2), .o_busy(busy2),
      .o_out_valid(out_valid2), .i_out_ready(out_ready2)
   );

   assign obs  = {ld_state, rnd_en, fin, out_valid, busy, in_ready, round};
   assign obs2 = {ld_state2, rnd_en2, fin2, out_valid2, busy2, in_ready2, round2};

   // Reference model: e is the block's progress (0 idle, 1 init, 2..n+1 rounds incl. final, n+2 out).
   function automatic logic [9:0] exp_vec(input int e, input logic key, input int n);
      logic [3:0] idx;
      if (e >= 2 && e <= n + 1) idx = 4'(e - 1);
      else if (e == n + 2)      idx = 4'(n);
      else                      idx = 4'd0;
      return {(e == 1) && key, (e >= 2 && e <= n + 1) && key, e == n + 1,
              e == n + 2, e >= 1, e == 0, idx};
   endfunction

   function automatic int next_e(input int e, input logic iv, input logic key,
                                 input logic ordy, input int n);
      if (e == 0)     return iv ? 1 : 0;
      if (e <= n + 1) return key ? e + 1 : e;
      return ordy ? 0 : e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 0; key_valid = 0; abort = 0; out_ready = 0;
      in_valid2 = 0; key_valid2 = 0; abort2 = 0; out_ready2 = 0;
      tick();
      tick();
      checks++;
      if (obs !== 10'd0) begin
         errors++;
         $display("FAIL reset_held: got %b expected %b", obs, 10'd0);
      end
      checks++;
      if (obs2 !== 10'd0) begin
         errors++;
         $display("FAIL reset_held_14: got %b expected %b", obs2, 10'd0);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (obs !== exp_vec(0, 1'b0, 10)) begin
         errors++;
         $display("FAIL reset_release: got %b expected %b", obs, exp_vec(0, 1'b0, 10));
      end
   endtask

   task automatic test_nominal();
      int e = 0;
      logic [9:0] exp;
      for (int c = 0; c <= 13; c++) begin
         tick();
         in_valid = (c == 0); key_valid = 1'b1; out_ready = 1'b1; abort = 1'b0;
         #1;
         exp = exp_vec(e, key_valid, 10);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL nominal cycle %0d: got %b expected %b", c, obs, exp);
         end
         e = next_e(e, in_valid, key_valid, out_ready, 10);
      end
   endtask

   task automatic test_key_stall();
      int e = 0;
      logic [9:0] exp;
      for (int c = 0; c <= 16; c++) begin
         tick();
         in_valid = (c == 0); key_valid = !(c >= 6 && c <= 8); out_ready = 1'b1;
         #1;
         exp = exp_vec(e, key_valid, 10);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL key_stall cycle %0d: got %b expected %b", c, obs, exp);
         end
         e = next_e(e, in_valid, key_valid, out_ready, 10);
      end
   endtask

   task automatic test_backpressure();
      int e = 0;
      logic [9:0] exp;
      for (int c = 0; c <= 17; c++) begin
         tick();
         in_valid = (c == 0); key_valid = 1'b1; out_ready = !(c >= 12 && c <= 15);
         #1;
         exp = exp_vec(e, key_valid, 10);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL backpressure cycle %0d: got %b expected %b", c, obs, exp);
         end
         e = next_e(e, in_valid, key_valid, out_ready, 10);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_abort();
      int e = 0;
      logic [9:0] exp;
      for (int c = 0; c <= 8; c++) begin
         tick();
         in_valid = (c == 0); key_valid = 1'b1; out_ready = 1'b1; abort = (c == 8);
         #1;
         exp = exp_vec(e, key_valid, 10);
         checks++;
         if (obs[7:0] !== exp[7:0]) begin
            errors++;
            $display("FAIL abort_run cycle %0d: got %b expected %b", c, obs[7:0], exp[7:0]);
         end
         e = next_e(e, in_valid, key_valid, out_ready, 10);
      end
      for (int c = 9; c <= 23; c++) begin
         tick();
         abort = 1'b0; in_valid = 1'b0;
         #1;
         checks++;
         if (obs !== exp_vec(0, 1'b1, 10)) begin
            errors++;
            $display("FAIL abort_idle cycle %0d: got %b expected %b", c, obs, exp_vec(0, 1'b1, 10));
         end
      end
   endtask

   task automatic test_abort_in_idle();
      tick();
      in_valid = 1'b1; abort = 1'b1; key_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_accept_ready: got %b expected %b", in_ready, 1'b0);
      end
      tick();
      in_valid = 1'b0; abort = 1'b0;
      #1;
      checks++;
      if (obs !== exp_vec(0, 1'b1, 10)) begin
         errors++;
         $display("FAIL abort_accept_state: got %b expected %b", obs, exp_vec(0, 1'b1, 10));
      end
   endtask

   task automatic test_reset_mid();
      int e = 0;
      logic [9:0] exp;
      for (int c = 0; c <= 5; c++) begin
         tick();
         in_valid = (c == 0); key_valid = 1'b1; out_ready = 1'b1;
         #1;
         exp = exp_vec(e, key_valid, 10);
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_run cycle %0d: got %b expected %b", c, obs, exp);
         end
         e = next_e(e, in_valid, key_valid, out_ready, 10);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (obs !== 10'd0) begin
         errors++;
         $display("FAIL reset_mid: got %b expected %b", obs, 10'd0);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (obs !== exp_vec(0, 1'b1, 10)) begin
         errors++;
         $display("FAIL reset_mid_release: got %b expected %b", obs, exp_vec(0, 1'b1, 10));
      end
   endtask

   task automatic test_rounds14();
      int e = 0;
      logic [9:0] exp;
      for (int c = 0; c <= 17; c++) begin
         tick();
         in_valid2 = (c == 0); key_valid2 = 1'b1; out_ready2 = 1'b1; abort2 = 1'b0;
         #1;
         exp = exp_vec(e, key_valid2, 14);
         checks++;
         if (obs2 !== exp) begin
            errors++;
            $display("FAIL rounds14 cycle %0d: got %b expected %b", c, obs2, exp);
         end
         e = next_e(e, in_valid2, key_valid2, out_ready2, 14);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_key_stall();
      test_backpressure();
      test_abort();
      test_abort_in_idle();
      test_reset_mid();
      test_rounds14();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
